// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one digit slot per SCAN_DIV clocks,
// frame-coherent input snapshot, leading-zero suppression and a blanking guard per slot.
module seg_scan_ctrl #(
   parameter int DIGITS      = 6,
   parameter int SCAN_DIV    = 50000,
   parameter int BLANK_CYC   = 500,
   parameter int SEL_ACT_LOW = 1,
   parameter int SEG_ACT_LOW = 1,
   localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   disp_data,
   input  logic [DIGITS-1:0]     disp_dp,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  lz_en,
   output logic [DIGITS-1:0]     seg_sel,
   output logic [7:0]            seg_led,
   output logic [IDX_W-1:0]      scan_idx,
   output logic                  frame_tick
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0]  BLANK_V  = DIV_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] SEL_INV  = {DIGITS{SEL_ACT_LOW != 0}};
   localparam logic [7:0]        SEG_INV  = {8{SEG_ACT_LOW != 0}};

   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
   logic [4*DIGITS-1:0] snap_data_q;
   logic [DIGITS-1:0]   snap_dp_q;
   logic [DIGITS-1:0]   snap_en_q;
   logic                snap_lz_q;
   logic                frame_tick_q;
   logic [DIGITS-1:0]   seg_sel_q, seg_sel_d;
   logic [7:0]          seg_led_q, seg_led_d;

   logic                frame_start;
   logic                slot_end;
   logic [4*DIGITS-1:0] eff_data;
   logic [DIGITS-1:0]   eff_dp;
   logic [DIGITS-1:0]   eff_en;
   logic                eff_lz;
   logic [DIGITS-1:0]   supp;
   logic                zero_above;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_on;
   logic [DIGITS-1:0]   sel_hot;
   logic                lit;

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign frame_start = (div_cnt_q == '0) && (scan_idx_q == '0);
   assign slot_end    = (div_cnt_q == DIV_LAST);

   always_comb begin
      div_cnt_d  = slot_end ? '0 : div_cnt_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (slot_end) begin
         scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
      end
   end

   // At frame start the snapshot is loading on this edge, so decode straight from the inputs.
   assign eff_data = frame_start ? disp_data : snap_data_q;
   assign eff_dp   = frame_start ? disp_dp   : snap_dp_q;
   assign eff_en   = frame_start ? digit_en  : snap_en_q;
   assign eff_lz   = frame_start ? lz_en     : snap_lz_q;

   always_comb begin
      zero_above = 1'b1;
      supp       = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (eff_data[4*i +: 4] == 4'h0);
         supp[i]    = eff_lz && zero_above && !eff_dp[i];
      end
   end

   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      cur_on  = 1'b0;
      sel_hot = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (scan_idx_q == IDX_W'(i)) begin
            cur_nib    = eff_data[4*i +: 4];
            cur_dp     = eff_dp[i];
            cur_on     = eff_en[i] && !supp[i];
            sel_hot[i] = 1'b1;
         end
      end
   end

   assign lit = cur_on && (div_cnt_q >= BLANK_V);

   always_comb begin
      seg_sel_d = SEL_INV;
      seg_led_d = SEG_INV;
      if (lit) begin
         seg_sel_d = sel_hot ^ SEL_INV;
         seg_led_d = {cur_dp, seg7(cur_nib)} ^ SEG_INV;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q    <= '0;
         scan_idx_q   <= '0;
         snap_data_q  <= '0;
         snap_dp_q    <= '0;
         snap_en_q    <= '0;
         snap_lz_q    <= 1'b0;
         frame_tick_q <= 1'b0;
         seg_sel_q    <= SEL_INV;
         seg_led_q    <= SEG_INV;
      end else begin
         div_cnt_q    <= div_cnt_d;
         scan_idx_q   <= scan_idx_d;
         frame_tick_q <= frame_start;
         seg_sel_q    <= seg_sel_d;
         seg_led_q    <= seg_led_d;
         if (frame_start) begin
            snap_data_q <= disp_data;
            snap_dp_q   <= disp_dp;
            snap_en_q   <= digit_en;
            snap_lz_q   <= lz_en;
         end
      end
   end

   assign seg_sel    = seg_sel_q;
   assign seg_led    = seg_led_q;
   assign scan_idx   = scan_idx_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIGITS=6, SCAN_DIV=8, BLANK_CYC=2, both outputs active-low.
module tb_seg_scan_ctrl;

   localparam int DIGITS = 6;
   localparam int SDIV   = 8;
   localparam int BLANK  = 2;
   localparam int FRAME  = DIGITS * SDIV;

   logic        clk;
   logic        rst_n;
   logic [23:0] disp_data;
   logic [5:0]  disp_dp;
   logic [5:0]  digit_en;
   logic        lz_en;
   logic [5:0]  seg_sel;
   logic [7:0]  seg_led;
   logic [2:0]  scan_idx;
   logic        frame_tick;

   seg_scan_ctrl #(
      .DIGITS(DIGITS), .SCAN_DIV(SDIV), .BLANK_CYC(BLANK),
      .SEL_ACT_LOW(1), .SEG_ACT_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .disp_data(disp_data), .disp_dp(disp_dp),
      .digit_en(digit_en), .lz_en(lz_en), .seg_sel(seg_sel), .seg_led(seg_led),
      .scan_idx(scan_idx), .frame_tick(frame_tick)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [23:0]     data;
      logic [5:0]      dp;
      logic [5:0]      en;
      logic            lz;
      logic [5:0]      lit;
      logic [5:0][7:0] led;
   } vec_t;

   vec_t tbl [9];
   logic [16:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic load_vec(input int v);
      disp_data = tbl[v].data;
      disp_dp   = tbl[v].dp;
      digit_en  = tbl[v].en;
      lz_en     = tbl[v].lz;
   endtask

   task automatic push_frame(input int v);
      for (int k = 0; k < FRAME; k++) begin
         int slot = k / SDIV;
         int d    = k % SDIV;
         int nk   = (k + 1) % FRAME;
         logic [5:0] s;
         logic [7:0] l;
         if (d >= BLANK && tbl[v].lit[slot]) begin
            s = ~(6'b000001 << slot);
            l = tbl[v].led[slot];
         end else begin
            s = 6'h3F;
            l = 8'hFF;
         end
         exp_q.push_back({s, l, 3'(nk / SDIV)});
      end
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) begin
            n = c;
            break;
         end
      end
      if (n == 0) begin
         checks++;
         errors++;
         $display("FAIL frame_tick_timeout: got none expected pulse within 200 cycles");
      end
   endtask

   // scoreboard: caller sits on the negedge where frame_tick was seen
   task automatic check_frame(input int mid_v);
      logic [16:0] e;
      for (int k = 0; k < FRAME; k++) begin
         if (k != 0) @(negedge clk);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got empty queue expected entry k=%0d", k);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("seg_sel k=%0d", k), 32'(seg_sel), 32'(e[16:11]));
            chk($sformatf("seg_led k=%0d", k), 32'(seg_led), 32'(e[10:3]));
            chk($sformatf("scan_idx k=%0d", k), 32'(scan_idx), 32'(e[2:0]));
         end
         if (k == 1) chk("frame_tick_width", 32'(frame_tick), 32'd0);
         if (mid_v >= 0 && k == 20) load_vec(mid_v);
      end
   endtask

   initial begin
      int n;
      tbl[0] = '{24'h012345, 6'h00, 6'h3F, 1'b0, 6'h3F, {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}};
      tbl[1] = '{24'h000070, 6'h00, 6'h3F, 1'b1, 6'h03, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hC0}};
      tbl[2] = '{24'h000070, 6'h08, 6'h3F, 1'b1, 6'h0B, {8'hFF, 8'hFF, 8'h40, 8'hFF, 8'hF8, 8'hC0}};
      tbl[3] = '{24'h89ABCD, 6'h21, 6'h2A, 1'b0, 6'h2A, {8'h00, 8'hFF, 8'h88, 8'hFF, 8'hC6, 8'hFF}};
      tbl[4] = '{24'h00E0F0, 6'h00, 6'h3F, 1'b1, 6'h0F, {8'hFF, 8'hFF, 8'h86, 8'hC0, 8'h8E, 8'hC0}};
      tbl[5] = '{24'h000000, 6'h00, 6'h3F, 1'b1, 6'h01, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
      tbl[6] = '{24'h654321, 6'h3F, 6'h3F, 1'b1, 6'h3F, {8'h02, 8'h12, 8'h19, 8'h30, 8'h24, 8'h79}};
      tbl[7] = '{24'h000000, 6'h00, 6'h3F, 1'b0, 6'h3F, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
      tbl[8] = '{24'hBD79E8, 6'h00, 6'h3F, 1'b1, 6'h3F, {8'h83, 8'hA1, 8'hF8, 8'h90, 8'h86, 8'h80}};

      // reset values
      rst_n = 1'b0;
      load_vec(0);
      repeat (3) @(negedge clk);
      chk("rst_seg_sel", 32'(seg_sel), 32'h3F);
      chk("rst_seg_led", 32'(seg_led), 32'hFF);
      chk("rst_scan_idx", 32'(scan_idx), 32'd0);
      chk("rst_frame_tick", 32'(frame_tick), 32'd0);

      // first snapshot on the first edge after release
      push_frame(0);
      rst_n = 1'b1;
      wait_tick(n);
      chk("first_tick_delay", 32'(n), 32'd1);
      check_frame(-1);

      // table-driven frames, each loaded right before the next frame start
      for (int v = 1; v < 9; v++) begin
         load_vec(v);
         push_frame(v);
         wait_tick(n);
         chk($sformatf("tick_delay v=%0d", v), 32'(n), 32'd1);
         check_frame(-1);
      end

      // frame period
      wait_tick(n);
      wait_tick(n);
      chk("frame_period", 32'(n), 32'(FRAME));

      // mid-frame change must not tear the current frame
      load_vec(0);
      wait_tick(n);
      wait_tick(n);
      push_frame(0);
      check_frame(6);
      push_frame(6);
      wait_tick(n);
      chk("tick_after_change", 32'(n), 32'd1);
      check_frame(-1);

      // asynchronous reset during a lit slot
      load_vec(0);
      wait_tick(n);
      wait_tick(n);
      repeat (4) @(negedge clk);
      chk("lit_before_rst_sel", 32'(seg_sel), 32'h3E);
      chk("lit_before_rst_led", 32'(seg_led), 32'h92);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_sel", 32'(seg_sel), 32'h3F);
      chk("async_rst_led", 32'(seg_led), 32'hFF);
      chk("async_rst_idx", 32'(scan_idx), 32'd0);
      @(negedge clk);
      load_vec(3);
      push_frame(3);
      rst_n = 1'b1;
      wait_tick(n);
      chk("restart_tick_delay", 32'(n), 32'd1);
      check_frame(-1);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
